// File: rtl/score_port_arbiter.sv
// Round-robin arbiter that shares one scoring unit among NUM_ST game stations,
// holding off after reset while the unit clears its RAM and timing out on a lost valid.
module score_port_arbiter #(
    parameter int NUM_ST      = 4,
    parameter int INIT_CYCLES = 160,
    parameter int TIMEOUT     = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ST-1:0]   st_req,
    input  logic [5*NUM_ST-1:0] st_id,
    input  logic [7*NUM_ST-1:0] st_score,
    output logic [NUM_ST-1:0]   st_done,
    output logic                res_pwinner,
    output logic                res_gwinner,
    output logic                res_err,
    output logic                sc_request,
    output logic [4:0]          sc_playerID,
    output logic [6:0]          sc_score,
    input  logic                sc_valid,
    input  logic                sc_pwinner,
    input  logic [4:0]          sc_gwinner,
    output logic                busy
);

    localparam int GW   = $clog2(NUM_ST);
    localparam int CMAX = (INIT_CYCLES > TIMEOUT) ? INIT_CYCLES : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_VALID,
        S_RESPOND
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [4:0]      id_q, id_d;
    logic [6:0]      score_q, score_d;
    logic            pwin_q, pwin_d;
    logic            gwin_q, gwin_d;
    logic            err_q, err_d;

    logic            found;
    logic [GW-1:0]   sel;
    logic [GW-1:0]   cand;
    logic [4:0]      sel_id;
    logic [6:0]      sel_score;

    // First requesting station at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int off = 0; off < NUM_ST; off++) begin
            cand = GW'((int'(ptr_q) + off) % NUM_ST);
            if (!found && st_req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        sel_id    = '0;
        sel_score = '0;
        for (int i = 0; i < NUM_ST; i++) begin
            if (sel == GW'(i)) begin
                sel_id    = st_id[5*i +: 5];
                sel_score = st_score[7*i +: 7];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        score_d = score_q;
        pwin_d  = pwin_q;
        gwin_d  = gwin_q;
        err_d   = err_q;
        case (state_q)
            S_INIT: begin
                if (cnt_q == CW'(INIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (found) begin
                    grant_d = sel;
                    id_d    = sel_id;
                    score_d = sel_score;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (sc_valid) begin
                    pwin_d  = sc_pwinner;
                    gwin_d  = |sc_gwinner;
                    err_d   = 1'b0;
                    state_d = S_RESPOND;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    pwin_d  = 1'b0;
                    gwin_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESPOND: begin
                ptr_d   = (grant_q == GW'(NUM_ST - 1)) ? '0 : grant_q + GW'(1);
                pwin_d  = 1'b0;
                gwin_d  = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            score_q <= '0;
            pwin_q  <= 1'b0;
            gwin_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            score_q <= score_d;
            pwin_q  <= pwin_d;
            gwin_q  <= gwin_d;
            err_q   <= err_d;
        end
    end

    // Result flops are only non-zero during RESPOND, so they drive the ports directly.
    always_comb begin
        st_done = '0;
        if (state_q == S_RESPOND) begin
            st_done[grant_q] = 1'b1;
        end
    end

    assign res_pwinner = pwin_q;
    assign res_gwinner = gwin_q;
    assign res_err     = err_q;
    assign sc_request  = (state_q == S_ISSUE);
    assign sc_playerID = id_q;
    assign sc_score    = score_q;
    assign busy        = (state_q != S_IDLE);

endmodule
